// File: rtl/keccak_arbiter_if.sv
// Purpose : bundles the requester-side and core-side buses of keccak_arbiter.
// Latency : none (wires only).
// Backpressure: carries in_ack and core_buffer_full; no logic of its own.
// Ports   : master = arbiter view, slave = clients + keccak core view.
interface keccak_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 3
);
  // requester side
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [32*NUM_REQ-1:0] in_data;
  logic [NUM_REQ-1:0]    in_valid;
  logic [NUM_REQ-1:0]    in_last;
  logic [2*NUM_REQ-1:0]  in_byte_num;
  logic [NUM_REQ-1:0]    in_ack;
  logic [NUM_REQ-1:0]    done;
  logic [511:0]          digest;
  logic [OWN_W-1:0]      owner_id;
  logic                  error;
  // keccak core side
  logic                  core_reset;
  logic [31:0]           core_in;
  logic                  core_in_ready;
  logic                  core_is_last;
  logic [1:0]            core_byte_num;
  logic                  core_buffer_full;
  logic [511:0]          core_out;
  logic                  core_out_ready;

  modport master (
    input  req, in_data, in_valid, in_last, in_byte_num,
    input  core_buffer_full, core_out, core_out_ready,
    output gnt, in_ack, done, digest, owner_id, error,
    output core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );

  modport slave (
    output req, in_data, in_valid, in_last, in_byte_num,
    output core_buffer_full, core_out, core_out_ready,
    input  gnt, in_ack, done, digest, owner_id, error,
    input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );
endinterface

// File: rtl/keccak_arbiter.sv
// Purpose : round-robin sharing of one keccak core among NUM_REQ message sources.
// Latency : grant 1 cycle after req seen in IDLE, one core-clear cycle, first word 2 cycles after req.
// Backpressure: owner words forwarded combinationally; core_buffer_full blocks ack and core_in_ready.
// Ports   : clk, reset (async, active high), bus (keccak_arbiter_if.master).
// Option  : define KECCAK_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles (error pulse).
module keccak_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 3,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  keccak_arbiter_if.master bus
);

  if ((2**OWN_W < NUM_REQ) || (NUM_REQ < 2) || (TIMEOUT < 2)) begin : g_bad_cfg
    $error("keccak_arbiter: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [511:0]         digest_q, digest_d;
  // owner_q doubles as the round-robin pointer: both always hold the last grantee
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic                 core_reset_q, core_reset_d;
  logic                 error_q, error_d;

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

  // owner-selected requester lane
  logic [NUM_REQ-1:0]   own_oh;
  logic                 own_vld;
  logic                 own_last;
  logic [31:0]          own_dat;
  logic [1:0]           own_bn;
  logic                 feed_rdy;

  // round-robin candidate
  logic                 pick_found;
  logic [OWN_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;

  always_comb begin
    own_oh   = '0;
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    own_bn   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_oh[i] = (owner_q == OWN_W'(i));
      if (own_oh[i]) begin
        own_vld  = bus.in_valid[i];
        own_last = bus.in_last[i];
        own_dat  = bus.in_data[32*i +: 32];
        own_bn   = bus.in_byte_num[2*i +: 2];
      end
    end
  end

  // Scan from farthest to nearest so the last hit is the first index after the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = owner_q;
    pick_oh    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (bus.req[(int'(owner_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = OWN_W'((int'(owner_q) + i) % NUM_REQ);
        pick_oh    = '0;
        pick_oh[(int'(owner_q) + i) % NUM_REQ] = 1'b1;
      end
    end
  end

  assign feed_rdy = (state_q == S_FEED) && own_vld && !bus.core_buffer_full;

  // Forwarding path is combinational so a word can move every cycle.
  assign bus.core_in       = (state_q == S_FEED) ? own_dat : '0;
  assign bus.core_byte_num = (state_q == S_FEED) ? own_bn  : '0;
  assign bus.core_in_ready = feed_rdy;
  assign bus.core_is_last  = feed_rdy && own_last;
  assign bus.in_ack        = feed_rdy ? own_oh : '0;

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.digest     = digest_q;
  assign bus.owner_id   = owner_q;
  assign bus.core_reset = core_reset_q;
  assign bus.error      = error_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    digest_d     = digest_q;
    owner_d      = owner_q;
    core_reset_d = 1'b0;
    error_d      = 1'b0;
`ifdef KECCAK_ARB_TIMEOUT_EN
    wait_cnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d      = pick_idx;
          gnt_d        = pick_oh;
          core_reset_d = 1'b1;   // high during the CLR cycle only
          state_d      = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_FEED;
      end
      S_FEED: begin
        if (feed_rdy && own_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.core_out_ready) begin
          digest_d = bus.core_out;
          done_d   = own_oh;
          state_d  = S_DONE;
        end
`ifdef KECCAK_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // abort: flush the core, keep the old digest, no done pulse
          error_d      = 1'b1;
          core_reset_d = 1'b1;
          gnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      digest_q     <= '0;
      owner_q      <= OWN_W'(NUM_REQ - 1);
      core_reset_q <= 1'b1;
      error_q      <= 1'b0;
`ifdef KECCAK_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      digest_q     <= digest_d;
      owner_q      <= owner_d;
      core_reset_q <= core_reset_d;
      error_q      <= error_d;
`ifdef KECCAK_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares one keccak core (32-bit word input, 512-bit digest) between NUM_REQ independent message sources.
- Grants the core to one requester per message, round-robin.
- Pulses the core's reset before each message and forwards that requester's words under the core's buffer_full backpressure.
- Captures the digest on out_ready and returns it to the owner with a done pulse.
- Sits between the hash clients and the keccak core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OWN_W, 3, width of owner index; must satisfy 2**OWN_W >= NUM_REQ.
- TIMEOUT, 1024, maximum cycles in WAIT before abort (only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester request, level.
- gnt  out  NUM_REQ  one-hot owner, zero when idle.
- in_data  in  32*NUM_REQ  packed words; requester k uses bits [32k+31:32k].
- in_valid  in  NUM_REQ  word valid.
- in_last  in  NUM_REQ  word is last of message.
- in_byte_num  in  2*NUM_REQ  valid bytes in last word (0..3).
- in_ack  out  NUM_REQ  word accepted this cycle.
- done  out  NUM_REQ  one-cycle digest-ready pulse to owner.
- digest  out  512  last captured digest.
- owner_id  out  OWN_W  index of current or last owner.
- core_reset  out  1  synchronous reset to core.
- core_in  out  32  word to core.
- core_in_ready  out  1  word valid to core.
- core_is_last  out  1  last flag to core.
- core_byte_num  out  2  byte count to core.
- core_buffer_full  in  1  core backpressure.
- core_out  in  512  core digest.
- core_out_ready  in  1  core digest valid.
- error  out  1  timeout abort pulse (tied 0 without the optional feature).

Behaviour:
- Reset values (asynchronous): state IDLE, gnt 0, in_ack 0, done 0, digest 0, owner_id NUM_REQ-1, core_reset 1, core_in_ready 0, core_is_last 0, core_byte_num 0, error 0, round-robin pointer NUM_REQ-1.
- core_reset drops on the first clk edge after reset is released.
- IDLE:
  - core_reset 0.
  - If any req is high, pick the first requesting index after the pointer, wrapping modulo NUM_REQ.
  - Register it into owner_id and the pointer, and set gnt.
  - Next state CLR.
- CLR: core_reset=1 for exactly one cycle. Next state FEED.
- FEED (combinational forwarding from the owner):
  - core_in = owner's word; core_byte_num = owner's byte_num.
  - core_in_ready = in_valid[owner] & ~core_buffer_full.
  - core_is_last = core_in_ready & in_last[owner].
  - in_ack[owner] = core_in_ready; in_ack of every other requester is 0.
  - Accepted last word: next state WAIT.
  - While core_buffer_full=1: no ack and no core_in_ready, whatever in_valid is.
- WAIT:
  - core_in_ready 0.
  - When core_out_ready=1, register core_out into digest. Next state DONE.
- DONE:
  - done[owner]=1 for one cycle; gnt is cleared at the end of DONE.
  - Next state IDLE. digest holds until the next capture.
- Minimum idle-to-grant latency is 1 cycle. The first word can be accepted 2 cycles after IDLE sees req.
- Inputs from non-owners are ignored.
- req is sampled only in IDLE. Deasserting req while granted does not release the core; the message must finish.
- byte_num is passed through unchanged. in_last with byte_num=0 is a legal empty final word.
- Reset asserted in any state returns to IDLE immediately with the values above. The in-flight message is discarded and no done pulse is given.

Optional Feature:
- Macro KECCAK_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT cycles pass without core_out_ready, the block pulses error=1 for one cycle.
  - It leaves digest unchanged and gives no done pulse.
  - It pulses core_reset for one cycle and returns to IDLE; the pointer advances normally.
- Not defined: no counter, error tied 0, WAIT is unbounded.

Test Plan:
- Reset:
  - Hold reset 3 cycles → gnt=0, core_reset=1, digest=0, owner_id=3.
  - After release → core_reset=0 on the next edge.
- Single message:
  - Only req[0]; words 32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, then 32'h21202020 with last, byte_num=1.
  - Required: gnt=4'b0001; one CLR cycle; four acks; core_is_last on the 4th word only.
  - The core model raises out_ready with a known pattern → digest equals that pattern and done=4'b0001 for one cycle.
- Round robin:
  - req=4'b0101 held, each message one word.
  - Required grant order: 0, 2, 0, 2, with a CLR pulse before each message.
- Backpressure:
  - core_buffer_full=1 for 5 cycles mid-message while in_valid=1.
  - Required: in_ack=0 and core_in_ready=0 for all 5 cycles; words resume in order with none lost or duplicated.
- Reset mid-message:
  - Assert reset in FEED after 2 words.
  - Required: immediate IDLE, no done; the next message from req[1] is granted and core_reset is pulsed.
- Timeout (with KECCAK_ARB_TIMEOUT_EN, TIMEOUT=16):
  - Never raise out_ready.
  - Required: error pulse 16 cycles after entering WAIT, core_reset pulse, digest unchanged, return to IDLE.
